dpram_be: RTL and testbench

DPRAM_BE -- requirements
Module: dpram_be

---
 rtl/mem_pkg.sv | 13 +
 rtl/dpram_rd_pipe.sv | 87 ++++++++
 rtl/dpram_be.sv | 215 +++++++++++++++++++++
 tb/tb_dpram_be.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enable dual-port RAM:
// the init state machine encoding and read-during-write mode codes.
package mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } init_state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-data / read-valid pipeline for one RAM port.
// Stage 1 is the array's registered output (plus forwarding merge, done by the
// parent); with RD_LAT=2 a plain output register follows, carrying data and
// valid together. Read data holds its last value between valid pulses.
module dpram_rd_pipe #(
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_acc,
   input  logic [DW-1:0] s1_data,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid
);

   logic v1_q;
   logic v1_d;

   // Stage-1 valid follows a read accepted on the previous edge
   always_comb begin
      v1_d = rd_acc;
   end

   // Stage-1 valid register, cleared so in-flight reads are dropped on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DW-1:0] d2_q;
         logic [DW-1:0] d2_d;
         logic          v2_q;
         logic          v2_d;

         // Output stage captures stage-1 data only when it is valid
         always_comb begin
            v2_d = v1_q;
            if (v1_q) begin
               d2_d = s1_data;
            end else begin
               d2_d = d2_q;
            end
         end

         // Output register for data and valid
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d2_q <= {DW{1'b0}};
               v2_q <= 1'b0;
            end else begin
               d2_q <= d2_d;
               v2_q <= v2_d;
            end
         end

         assign rd_data  = d2_q;
         assign rd_valid = v2_q;
      end else begin : g_lat1
         logic seen_q;
         logic seen_d;

         // Tracks whether any read completed since reset, so data reads as zero until then
         always_comb begin
            seen_d = seen_q | rd_acc;
         end

         // Read-seen flag register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               seen_q <= 1'b0;
            end else begin
               seen_q <= seen_d;
            end
         end

         assign rd_data  = seen_q ? s1_data : {DW{1'b0}};
         assign rd_valid = v1_q;
      end
   endgenerate

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, configurable read latency,
// cross-port read-during-write forwarding and an optional post-reset clear.
module dpram_be
   import mem_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 10,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0,
   parameter int CLEAR_EN = 1
) (
   input  logic            CLK,
   input  logic            RESET,
   output logic            READY,
   input  logic            A_REQ,
   input  logic            A_WE,
   input  logic [DW/8-1:0] A_BE,
   input  logic [AW-1:0]   A_ADDR,
   input  logic [DW-1:0]   A_WD,
   output logic [DW-1:0]   A_RD,
   output logic            A_RVALID,
   input  logic            B_REQ,
   input  logic            B_WE,
   input  logic [DW/8-1:0] B_BE,
   input  logic [AW-1:0]   B_ADDR,
   input  logic [DW-1:0]   B_WD,
   output logic [DW-1:0]   B_RD,
   output logic            B_RVALID
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   // Replace the bytes selected by mask with the corresponding bytes of new_w
   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NB-1:0] mask);
      logic [DW-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (mask[i]) begin
            res[i*8 +: 8] = new_w[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_w[i*8 +: 8];
         end
      end
      return res;
   endfunction

   logic [DW-1:0] mem [DEPTH];

   init_state_e   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;

   logic          a_wr_s, a_rd_s, b_wr_s, b_rd_s, same_addr_s;
   logic          pa_we_s, pb_we_s;
   logic [NB-1:0] pa_be_s, pb_be_s;
   logic [AW-1:0] pa_addr_s;
   logic [DW-1:0] pa_wd_s;

   logic [DW-1:0] a_raw_q, b_raw_q;
   logic [NB-1:0] a_fmask_q, a_fmask_d, b_fmask_q, b_fmask_d;
   logic [DW-1:0] a_fwd_q, a_fwd_d, b_fwd_q, b_fwd_d;
   logic [DW-1:0] a_s1_s, b_s1_s;

   // Init FSM next state: walk the clear counter through every word, then run
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == {AW{1'b1}}) begin
               state_d = RUN;
            end else begin
               state_d = CLEAR;
            end
         end
         RUN: begin
            state_d = RUN;
            cnt_d   = cnt_q;
         end
         default: begin
            state_d = RUN;
            cnt_d   = {AW{1'b0}};
         end
      endcase
      ready_d = (state_d == RUN);
   end

   // Init FSM state, clear counter and registered READY
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= (CLEAR_EN != 0) ? CLEAR : RUN;
         cnt_q   <= {AW{1'b0}};
         ready_q <= (CLEAR_EN == 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign READY = ready_q;

   // Request decode and write-port steering (clear borrows port A's write path)
   always_comb begin
      a_wr_s      = A_REQ & ready_q & A_WE;
      a_rd_s      = A_REQ & ready_q & ~A_WE;
      b_wr_s      = B_REQ & ready_q & B_WE;
      b_rd_s      = B_REQ & ready_q & ~B_WE;
      same_addr_s = (A_ADDR == B_ADDR);
      if (state_q == CLEAR) begin
         pa_we_s   = 1'b1;
         pa_be_s   = {NB{1'b1}};
         pa_addr_s = cnt_q;
         pa_wd_s   = {DW{1'b0}};
      end else begin
         pa_we_s   = a_wr_s;
         pa_be_s   = A_BE;
         pa_addr_s = A_ADDR;
         pa_wd_s   = A_WD;
      end
      pb_we_s = b_wr_s;
      if (a_wr_s && b_wr_s && same_addr_s) begin
         pb_be_s = B_BE & ~A_BE;
      end else begin
         pb_be_s = B_BE;
      end
   end

   // Byte-enabled dual-port array with registered old-data reads
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NB; i++) begin
         if (pa_we_s && pa_be_s[i]) begin
            mem[pa_addr_s][i*8 +: 8] <= pa_wd_s[i*8 +: 8];
         end
         if (pb_we_s && pb_be_s[i]) begin
            mem[B_ADDR][i*8 +: 8] <= B_WD[i*8 +: 8];
         end
      end
      if (a_rd_s) begin
         a_raw_q <= mem[A_ADDR];
      end
      if (b_rd_s) begin
         b_raw_q <= mem[B_ADDR];
      end
   end

   // Capture the other port's same-address write so a new-data read can merge it
   always_comb begin
      a_fmask_d = a_fmask_q;
      a_fwd_d   = a_fwd_q;
      b_fmask_d = b_fmask_q;
      b_fwd_d   = b_fwd_q;
      if (a_rd_s) begin
         if ((RDW_MODE == RDW_NEW) && b_wr_s && same_addr_s) begin
            a_fmask_d = B_BE;
            a_fwd_d   = B_WD;
         end else begin
            a_fmask_d = {NB{1'b0}};
         end
      end else begin
         a_fmask_d = a_fmask_q;
      end
      if (b_rd_s) begin
         if ((RDW_MODE == RDW_NEW) && a_wr_s && same_addr_s) begin
            b_fmask_d = A_BE;
            b_fwd_d   = A_WD;
         end else begin
            b_fmask_d = {NB{1'b0}};
         end
      end else begin
         b_fmask_d = b_fmask_q;
      end
   end

   // Forwarding registers, aligned with the array's read register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         a_fmask_q <= {NB{1'b0}};
         a_fwd_q   <= {DW{1'b0}};
         b_fmask_q <= {NB{1'b0}};
         b_fwd_q   <= {DW{1'b0}};
      end else begin
         a_fmask_q <= a_fmask_d;
         a_fwd_q   <= a_fwd_d;
         b_fmask_q <= b_fmask_d;
         b_fwd_q   <= b_fwd_d;
      end
   end

   assign a_s1_s = merge_bytes(a_raw_q, a_fwd_q, a_fmask_q);
   assign b_s1_s = merge_bytes(b_raw_q, b_fwd_q, b_fmask_q);

   dpram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_a (
      .clk      (CLK),
      .rst      (RESET),
      .rd_acc   (a_rd_s),
      .s1_data  (a_s1_s),
      .rd_data  (A_RD),
      .rd_valid (A_RVALID)
   );

   dpram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_b (
      .clk      (CLK),
      .rst      (RESET),
      .rd_acc   (b_rd_s),
      .s1_data  (b_s1_s),
      .rd_data  (B_RD),
      .rd_valid (B_RVALID)
   );

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances share stimulus, one with RD_LAT=1 and
// old-data collisions, one with RD_LAT=2 and new-data collisions.
module tb_dpram_be;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [3:0]  a_be, b_be, a_addr, b_addr;
   logic [31:0] a_wd, b_wd;

   logic        r1_ready, r1_a_rvalid, r1_b_rvalid;
   logic [31:0] r1_a_rd, r1_b_rd;
   logic        r2_ready, r2_a_rvalid, r2_b_rvalid;
   logic [31:0] r2_a_rd, r2_b_rd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dpram_be #(.DW(32), .AW(4), .RD_LAT(1), .RDW_MODE(0), .CLEAR_EN(1)) u_d1 (
      .CLK(clk), .RESET(rst), .READY(r1_ready),
      .A_REQ(a_req), .A_WE(a_we), .A_BE(a_be), .A_ADDR(a_addr), .A_WD(a_wd),
      .A_RD(r1_a_rd), .A_RVALID(r1_a_rvalid),
      .B_REQ(b_req), .B_WE(b_we), .B_BE(b_be), .B_ADDR(b_addr), .B_WD(b_wd),
      .B_RD(r1_b_rd), .B_RVALID(r1_b_rvalid)
   );

   dpram_be #(.DW(32), .AW(4), .RD_LAT(2), .RDW_MODE(1), .CLEAR_EN(1)) u_d2 (
      .CLK(clk), .RESET(rst), .READY(r2_ready),
      .A_REQ(a_req), .A_WE(a_we), .A_BE(a_be), .A_ADDR(a_addr), .A_WD(a_wd),
      .A_RD(r2_a_rd), .A_RVALID(r2_a_rvalid),
      .B_REQ(b_req), .B_WE(b_we), .B_BE(b_be), .B_ADDR(b_addr), .B_WD(b_wd),
      .B_RD(r2_b_rd), .B_RVALID(r2_b_rvalid)
   );

   typedef struct {
      bit          port_b;
      bit          we;
      logic [3:0]  be;
      logic [3:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_wd = 32'h0;
      b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 4'h0; b_wd = 32'h0;
   endtask

   // Count cycles until READY rises (bounded); a full clear is 16 cycles
   task automatic wait_clear(input string name);
      int cnt;
      cnt = 0;
      while (r1_ready !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      check(name, cnt, 32'd16);
      check({name, "_ready2"}, {31'd0, r2_ready}, 32'd1);
   endtask

   task automatic drive(input bit port_b, input bit we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] wd);
      if (port_b) begin
         b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wd = wd;
      end else begin
         a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wd = wd;
      end
   endtask

   task automatic do_write(input bit port_b, input logic [3:0] be,
                           input logic [3:0] addr, input logic [31:0] wd);
      drive(port_b, 1'b1, be, addr, wd);
      tick();
      idle();
      check("wr_no_rvalid", {28'd0, r1_a_rvalid, r1_b_rvalid, r2_a_rvalid, r2_b_rvalid}, 32'd0);
   endtask

   // Issue one read; check the LAT=1 pulse, then the LAT=2 pulse and LAT=1 hold
   task automatic do_read(input string name, input bit port_b, input logic [3:0] be,
                          input logic [3:0] addr, input logic [31:0] exp1,
                          input logic [31:0] exp2);
      drive(port_b, 1'b0, be, addr, 32'h0);
      tick();
      idle();
      check({name, "_v1"}, {31'd0, port_b ? r1_b_rvalid : r1_a_rvalid}, 32'd1);
      check({name, "_d1"}, port_b ? r1_b_rd : r1_a_rd, exp1);
      check({name, "_v2early"}, {31'd0, port_b ? r2_b_rvalid : r2_a_rvalid}, 32'd0);
      tick();
      check({name, "_v1end"}, {31'd0, port_b ? r1_b_rvalid : r1_a_rvalid}, 32'd0);
      check({name, "_d1hold"}, port_b ? r1_b_rd : r1_a_rd, exp1);
      check({name, "_v2"}, {31'd0, port_b ? r2_b_rvalid : r2_a_rvalid}, 32'd1);
      check({name, "_d2"}, port_b ? r2_b_rd : r2_a_rd, exp2);
   endtask

   // One port writes addr 7 while the other reads it in the same cycle
   task automatic rdw(input string name, input bit wr_b, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] exp_old,
                      input logic [31:0] exp_new);
      drive(wr_b, 1'b1, be, 4'd7, wd);
      drive(!wr_b, 1'b0, 4'hF, 4'd7, 32'h0);
      tick();
      idle();
      check({name, "_old"}, wr_b ? r1_a_rd : r1_b_rd, exp_old);
      tick();
      check({name, "_new"}, wr_b ? r2_a_rd : r2_b_rd, exp_new);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bit seen;

      vecs[0]  = '{1'b0, 1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 4'h5, 4'd3,  32'h11223344, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 4'hF, 4'd3,  32'h0,        32'hAA22CC44};
      vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'd3,  32'hFFFFFFFF, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'd3,  32'h0,        32'hAA22CC44};
      vecs[5]  = '{1'b1, 1'b0, 4'hF, 4'd3,  32'h0,        32'hAA22CC44};
      vecs[6]  = '{1'b1, 1'b1, 4'hA, 4'd9,  32'hCAFEBABE, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'd9,  32'h0,        32'hCA00BA00};
      vecs[8]  = '{1'b1, 1'b1, 4'hF, 4'd15, 32'h01234567, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 4'hF, 4'd15, 32'h0,        32'h01234567};
      vecs[10] = '{1'b0, 1'b1, 4'h8, 4'd0,  32'h5AFFFFFF, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 4'hF, 4'd0,  32'h0,        32'h5A000000};

      // Reset state
      idle();
      rst = 1'b1;
      tick();
      tick();
      check("rst_ready", {30'd0, r1_ready, r2_ready}, 32'd0);
      check("rst_rvalid", {28'd0, r1_a_rvalid, r1_b_rvalid, r2_a_rvalid, r2_b_rvalid}, 32'd0);
      check("rst_rd1", r1_a_rd | r1_b_rd, 32'h0);
      check("rst_rd2", r2_a_rd | r2_b_rd, 32'h0);
      rst = 1'b0;
      wait_clear("clear1");

      // Preload non-zero, reset again with an ignored write held during clear
      for (int i = 0; i < 16; i++) begin
         do_write(1'b0, 4'hF, 4'(i), 32'hA5A50001 + 32'(i));
      end
      rst = 1'b1;
      drive(1'b0, 1'b1, 4'hF, 4'd2, 32'hDEADBEEF);
      tick();
      rst = 1'b0;
      wait_clear("clear2");
      idle();
      for (int i = 0; i < 16; i++) begin
         do_read($sformatf("zero%0d", i), 1'b0, 4'hF, 4'(i), 32'h0, 32'h0);
      end

      // Table of directed accesses
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].we) begin
            do_write(vecs[i].port_b, vecs[i].be, vecs[i].addr, vecs[i].wd);
         end else begin
            do_read($sformatf("vec%0d", i), vecs[i].port_b, vecs[i].be, vecs[i].addr,
                    vecs[i].exp, vecs[i].exp);
         end
      end

      // Back-to-back reads give back-to-back pulses
      drive(1'b0, 1'b0, 4'hF, 4'd3, 32'h0);
      tick();
      a_addr = 4'd9;
      check("b2b_v1a", {31'd0, r1_a_rvalid}, 32'd1);
      tick();
      idle();
      check("b2b_v1b", {31'd0, r1_a_rvalid}, 32'd1);
      check("b2b_d1b", r1_a_rd, 32'hCA00BA00);
      check("b2b_v2a", {31'd0, r2_a_rvalid}, 32'd1);
      check("b2b_d2a", r2_a_rd, 32'hAA22CC44);
      tick();
      check("b2b_v2b", {31'd0, r2_a_rvalid}, 32'd1);
      check("b2b_d2b", r2_a_rd, 32'hCA00BA00);
      tick();

      // Same-address write collision: A wins shared bytes
      drive(1'b0, 1'b1, 4'h1, 4'd5, 32'h000000FF);
      drive(1'b1, 1'b1, 4'h3, 4'd5, 32'h12345678);
      tick();
      idle();
      do_read("coll", 1'b0, 4'hF, 4'd5, 32'h000056FF, 32'h000056FF);

      // Cross-port read-during-write
      do_write(1'b0, 4'hF, 4'd7, 32'h1);
      rdw("rdw_awr", 1'b0, 4'hF, 32'h2, 32'h1, 32'h2);
      rdw("rdw_bwr", 1'b1, 4'hF, 32'h3, 32'h2, 32'h3);
      rdw("rdw_part", 1'b0, 4'h2, 32'h0000AB00, 32'h3, 32'h0000AB03);
      do_read("rdw_final", 1'b1, 4'hF, 4'd7, 32'h0000AB03, 32'h0000AB03);

      // Reset at clear count 9 restarts a full clear
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
      end
      check("midclr_notready", {31'd0, r1_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_clear("clear_restart");

      // Reset one cycle after a read is accepted discards it
      drive(1'b0, 1'b0, 4'hF, 4'd7, 32'h0);
      tick();
      idle();
      rst = 1'b1;
      #1;
      check("rstrd_v", {30'd0, r1_a_rvalid, r2_a_rvalid}, 32'd0);
      check("rstrd_d1", r1_a_rd, 32'h0);
      check("rstrd_d2", r2_a_rd, 32'h0);
      tick();
      rst = 1'b0;
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (r1_ready !== 1'b1) cnt++;
         if (r1_a_rvalid || r1_b_rvalid || r2_a_rvalid || r2_b_rvalid) seen = 1'b1;
         tick();
      end
      check("rstrd_clear", cnt, 32'd16);
      check("rstrd_no_rvalid", {31'd0, seen}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
